// File: rtl/y86_pkg.sv
// Y86-64 shared encodings and the write-back entry type.
// Used by decode, write-back and the register-file sequencer.
package y86_pkg;

  localparam logic [3:0] RAX   = 4'h0;
  localparam logic [3:0] RCX   = 4'h1;
  localparam logic [3:0] RDX   = 4'h2;
  localparam logic [3:0] RBX   = 4'h3;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RBP   = 4'h5;
  localparam logic [3:0] RSI   = 4'h6;
  localparam logic [3:0] RDI   = 4'h7;
  localparam logic [3:0] R8    = 4'h8;
  localparam logic [3:0] R9    = 4'h9;
  localparam logic [3:0] R10   = 4'hA;
  localparam logic [3:0] R11   = 4'hB;
  localparam logic [3:0] R12   = 4'hC;
  localparam logic [3:0] R13   = 4'hD;
  localparam logic [3:0] R14   = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef struct packed {
    logic [3:0]  addr;
    logic [63:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_sequencer_if.sv
// Write-back bundle handshake from the retire stage.
// master drives the bundle, slave returns ready.
interface regfile_wb_sequencer_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_dstE;
  logic [63:0] wb_valE;
  logic [3:0]  wb_dstM;
  logic [63:0] wb_valM;

  modport master (
    output wb_valid, wb_dstE, wb_valE,
    output wb_dstM, wb_valM,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_dstE, wb_valE,
    input  wb_dstM, wb_valM,
    output wb_ready
  );
endinterface

// File: rtl/wb_queue.sv
// Circular write queue: two push slots per cycle, one pop.
// push1 lands in the slot after push0 and is honoured only with push0.
module wb_queue
  import y86_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push0,
  input  wb_entry_t                  push0_entry,
  input  logic                       push1,
  input  wb_entry_t                  push1_entry,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_pop;
  logic            do_push1;

  always_comb begin
    mem_d    = mem_q;
    do_pop   = pop & (count_q != '0);
    do_push1 = push0 & push1;
    if (push0) begin
      mem_d[wr_ptr_q] = push0_entry;
    end
    if (do_push1) begin
      mem_d[wr_ptr_q + PW'(1)] = push1_entry;
    end
    wr_ptr_d = wr_ptr_q + PW'(push0)
             + PW'(do_push1);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(push0)
             + CW'(do_push1) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: empty masks stale slots.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/regfile_wb_sequencer.sv
// Serialises E/M write-back results onto the single register-file
// write port and tracks per-register pending writes for decode stalls.
module regfile_wb_sequencer
  import y86_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NREG  = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_wb_sequencer_if.slave  wb,
  output logic                   rf_we,
  output logic [3:0]             rf_waddr,
  output logic [63:0]            rf_wdata,
  input  logic [3:0]             srcA,
  input  logic [3:0]             srcB,
  output logic                   busyA,
  output logic                   busyB,
  output logic                   idle
);

  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0] count;
  logic          empty;
  wb_entry_t     head;
  wb_entry_t     e_entry;
  wb_entry_t     m_entry;
  wb_entry_t     push0_entry;
  logic          accept;
  logic          push_e;
  logic          push_m;
  logic          push0;
  logic          push1;
  logic          pop;
  logic [CW-1:0] pend_q [NREG];
  logic [CW-1:0] pend_d [NREG];

  // Two free slots guarantee any bundle fits.
  assign wb.wb_ready = (count <= CW'(DEPTH-2));
  assign accept      = wb.wb_valid & wb.wb_ready;

  always_comb begin
    push_e      = accept & (wb.wb_dstE != RNONE);
    push_m      = accept & (wb.wb_dstM != RNONE);
    e_entry     = '{addr: wb.wb_dstE,
                    data: wb.wb_valE};
    m_entry     = '{addr: wb.wb_dstM,
                    data: wb.wb_valM};
    push0       = push_e | push_m;
    push1       = push_e & push_m;
    push0_entry = push_e ? e_entry : m_entry;
    pop         = !empty;
  end

  wb_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .push0       (push0),
    .push0_entry (push0_entry),
    .push1       (push1),
    .push1_entry (m_entry),
    .pop         (pop),
    .head        (head),
    .empty       (empty),
    .count       (count)
  );

  always_comb begin
    rf_we    = pop;
    rf_waddr = empty ? RNONE : head.addr;
    rf_wdata = empty ? 64'd0 : head.data;
    idle     = empty;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r]
        + CW'(push_e && wb.wb_dstE == 4'(r))
        + CW'(push_m && wb.wb_dstM == 4'(r))
        - CW'(pop && head.addr == 4'(r));
    end
  end

  always_comb begin
    busyA = 1'b0;
    busyB = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (srcA == 4'(r) && pend_q[r] != '0)
        busyA = 1'b1;
      if (srcB == 4'(r) && pend_q[r] != '0)
        busyB = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (reset) pend_q[r] <= '0;
      else       pend_q[r] <= pend_d[r];
    end
  end

endmodule

// File: tb/tb_regfile_wb_sequencer.sv
// Randomised bench for the write-back sequencer against a
// queue-of-pending-writes reference model.
module tb_regfile_wb_sequencer;

  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  a;
    logic [63:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [3:0]  srcA, srcB;
  logic        busyA, busyB, idle;

  int n_checks = 0;
  int n_errors = 0;
  ent_t mq[$];

  always #5 clk = ~clk;

  regfile_wb_sequencer_if wb_if ();

  regfile_wb_sequencer #(
    .DEPTH (DEPTH),
    .NREG  (15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb       (wb_if),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .srcA     (srcA),
    .srcB     (srcB),
    .busyA    (busyA),
    .busyB    (busyB),
    .idle     (idle)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic bit m_pending(input logic [3:0] r);
    if (r == 4'hF) return 1'b0;
    foreach (mq[i]) if (mq[i].a == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all();
    bit ne;
    ne = (mq.size() != 0);
    chk("rf_we", rf_we, ne);
    chk("rf_waddr", rf_waddr, ne ? mq[0].a : 4'hF);
    chk("rf_wdata", rf_wdata, ne ? mq[0].d : 64'd0);
    chk("idle", idle, !ne);
    chk("wb_ready", wb_if.wb_ready,
        mq.size() <= DEPTH - 2);
    chk("busyA", busyA, m_pending(srcA));
    chk("busyB", busyB, m_pending(srcB));
  endtask

  // Called at a negedge; returns at the next negedge after checking.
  task automatic step(input logic v,
                      input logic [3:0] de,
                      input logic [63:0] ve,
                      input logic [3:0] dm,
                      input logic [63:0] vm,
                      input logic [3:0] sa,
                      input logic [3:0] sb,
                      input logic rst);
    bit acc;
    wb_if.wb_valid = v;
    wb_if.wb_dstE  = de;
    wb_if.wb_valE  = ve;
    wb_if.wb_dstM  = dm;
    wb_if.wb_valM  = vm;
    srcA  = sa;
    srcB  = sb;
    reset = rst;
    acc = v && (mq.size() <= DEPTH - 2);
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      if (acc && de != 4'hF) mq.push_back('{de, ve});
      if (acc && dm != 4'hF) mq.push_back('{dm, vm});
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_step(input logic [3:0] sa,
                           input logic [3:0] sb);
    step(1'b0, 4'hF, 64'd0, 4'hF, 64'd0,
         sa, sb, 1'b0);
  endtask

  function automatic logic [3:0] rnd_dst();
    if ($urandom_range(0, 4) == 0) return 4'hF;
    return 4'($urandom_range(0, 5));
  endfunction

  initial begin
    logic [63:0] rv;
    wb_if.wb_valid = 1'b0;
    wb_if.wb_dstE  = 4'hF;
    wb_if.wb_valE  = '0;
    wb_if.wb_dstM  = 4'hF;
    wb_if.wb_valM  = '0;
    srcA  = 4'hF;
    srcB  = 4'hF;
    reset = 1'b1;
    @(negedge clk);
    step(1'b0, 4'hF, 0, 4'hF, 0, 4'h3, 4'h4, 1'b1);
    chk("reset_waddr", rf_waddr, 4'hF);
    chk("reset_ready", wb_if.wb_ready, 1'b1);

    // single E write
    step(1'b1, 4'h3, 64'h11, 4'hF, 0, 4'h3, 4'hF, 1'b0);
    chk("t1_we", rf_we, 1'b1);
    chk("t1_busyA", busyA, 1'b1);
    idle_step(4'h3, 4'hF);
    chk("t1_idle", idle, 1'b1);

    // E and M to the same register: M lands last
    step(1'b1, 4'h4, 64'h100, 4'h4, 64'h200,
         4'hF, 4'h4, 1'b0);
    chk("t2_wdata1", rf_wdata, 64'h100);
    idle_step(4'hF, 4'h4);
    chk("t2_wdata2", rf_wdata, 64'h200);
    chk("t2_busyB", busyB, 1'b1);
    idle_step(4'hF, 4'h4);
    chk("t2_clear", busyB, 1'b0);

    // saturating stream of double bundles
    for (int i = 0; i < 16; i++) begin
      rv = {$urandom, $urandom};
      step(1'b1, 4'(i % 15), rv,
           4'((i + 7) % 15), ~rv,
           4'(i % 15), 4'hF, 1'b0);
    end
    repeat (6) idle_step(4'h1, 4'h2);

    // empty bundle
    step(1'b1, 4'hF, 64'h5, 4'hF, 64'h6,
         4'hF, 4'hF, 1'b0);
    chk("t4_idle", idle, 1'b1);

    // push to 1 and 2 while 1 pops
    step(1'b1, 4'h1, 64'hA1, 4'hF, 0, 4'h1, 4'h2, 1'b0);
    step(1'b1, 4'h1, 64'hA2, 4'h2, 64'hA3,
         4'h1, 4'h2, 1'b0);
    chk("t5_busyA", busyA, 1'b1);
    idle_step(4'h1, 4'h2);
    chk("t5_busyA2", busyA, 1'b0);
    idle_step(4'h1, 4'h2);

    // reset with three entries queued
    step(1'b1, 4'h5, 64'h55, 4'h6, 64'h66,
         4'h5, 4'h6, 1'b0);
    step(1'b1, 4'h7, 64'h77, 4'h8, 64'h88,
         4'h7, 4'h8, 1'b0);
    chk("t6_full", wb_if.wb_ready, 1'b0);
    step(1'b0, 4'hF, 0, 4'hF, 0, 4'h7, 4'h8, 1'b1);
    chk("t6_we", rf_we, 1'b0);
    chk("t6_ready", wb_if.wb_ready, 1'b1);
    repeat (3) idle_step(4'h7, 4'h8);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0,
           rnd_dst(), {$urandom, $urandom},
           rnd_dst(), {$urandom, $urandom},
           rnd_dst(), rnd_dst(),
           $urandom_range(0, 99) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
